// File: rtl/time_dmr_pkg.sv
// Shared types and ID helper for the time-redundant (DMR) start/end pair.
package time_dmr_pkg;

   typedef enum logic [1:0] {
      EMPTY       = 2'd0,
      SEND_FIRST  = 2'd1,
      SEND_SECOND = 2'd2
   } dmr_state_e;

   localparam int unsigned MAX_ID_W = 32;

   // Builds {^cnt, cnt} for a counter of cnt_w bits; the result always has even parity.
   function automatic logic [MAX_ID_W-1:0] build_id(
      input logic [MAX_ID_W-2:0] cnt,
      input logic [4:0]          cnt_w
   );
      logic [MAX_ID_W-1:0] id;
      id        = {1'b0, cnt};
      id[cnt_w] = ^cnt;
      return id;
   endfunction

endpackage

// File: rtl/time_dmr_id_gen.sv
// ID counter for time_dmr_start: counter, wrap-around increment and next-ID generation.
module time_dmr_id_gen
   import time_dmr_pkg::*;
#(
   parameter int IDSize = 2
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              inc_i,
   output logic [IDSize-1:0] next_id_o
);

   logic [IDSize-2:0] cnt_r;

   // Counter advances once per newly accepted upstream element, wrapping naturally.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_r <= '0;
      end else if (inc_i) begin
         cnt_r <= cnt_r + (IDSize-1)'(1'b1);
      end else begin
         cnt_r <= cnt_r;
      end
   end

   assign next_id_o = IDSize'(build_id((MAX_ID_W-1)'(cnt_r), 5'(IDSize-1)));

endmodule

// File: rtl/time_dmr_start.sv
// Front half of time-redundant DMR: each accepted element is emitted twice with the same ID.
// Optional retry input port set is enabled by defining TIME_DMR_RETRY_EN.
module time_dmr_start
   import time_dmr_pkg::*;
#(
   parameter type DataType = logic,
   parameter int  IDSize   = 2
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              enable_i,
   output logic [IDSize-1:0] next_id_o,
   input  DataType           data_i,
   input  logic              valid_i,
   output logic              ready_o,
`ifdef TIME_DMR_RETRY_EN
   input  DataType           retry_data_i,
   input  logic [IDSize-1:0] retry_id_i,
   input  logic              retry_valid_i,
   output logic              retry_ready_o,
`endif
   output DataType           data_o,
   output logic [IDSize-1:0] id_o,
   output logic              valid_o,
   input  logic              ready_i
);

   dmr_state_e        state_r;
   DataType           data_r;
   logic [IDSize-1:0] id_r;

   logic              load_slot_s;
   logic              take_new_s;
   logic              take_retry_s;
   logic              load_s;
   logic              retry_block_s;
   DataType           load_data_s;
   logic [IDSize-1:0] load_id_s;
   logic [IDSize-1:0] next_id_s;

   time_dmr_id_gen #(
      .IDSize (IDSize)
   ) u_id_gen (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .inc_i     (take_new_s),
      .next_id_o (next_id_s)
   );

   assign next_id_o = next_id_s;

   // A load slot is the cycle in which the buffer may take a new element.
   always_comb begin
      load_slot_s = 1'b0;
      if (!enable_i) begin
         load_slot_s = 1'b0;
      end else if (state_r == EMPTY) begin
         load_slot_s = 1'b1;
      end else if ((state_r == SEND_SECOND) && ready_i) begin
         load_slot_s = 1'b1;
      end else begin
         load_slot_s = 1'b0;
      end
   end

`ifdef TIME_DMR_RETRY_EN
   // Retried elements win the slot and keep their original ID.
   assign retry_block_s = retry_valid_i;
   assign take_retry_s  = load_slot_s & retry_valid_i;
   assign take_new_s    = load_slot_s & valid_i & ~retry_valid_i;
   assign load_data_s   = take_retry_s ? retry_data_i : data_i;
   assign load_id_s     = take_retry_s ? retry_id_i : next_id_s;
   assign retry_ready_o = load_slot_s;
`else
   assign retry_block_s = 1'b0;
   assign take_retry_s  = 1'b0;
   assign take_new_s    = load_slot_s & valid_i;
   assign load_data_s   = data_i;
   assign load_id_s     = next_id_s;
`endif

   assign load_s = take_retry_s | take_new_s;

   // Sequencer: buffer an element, then hold it for two downstream handshakes.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_r <= EMPTY;
         data_r  <= '0;
         id_r    <= '0;
      end else if (!enable_i) begin
         state_r <= EMPTY;
      end else begin
         case (state_r)
            EMPTY: begin
               if (load_s) begin
                  state_r <= SEND_FIRST;
                  data_r  <= load_data_s;
                  id_r    <= load_id_s;
               end else begin
                  state_r <= EMPTY;
               end
            end
            SEND_FIRST: begin
               if (ready_i) begin
                  state_r <= SEND_SECOND;
               end else begin
                  state_r <= SEND_FIRST;
               end
            end
            SEND_SECOND: begin
               if (ready_i && load_s) begin
                  state_r <= SEND_FIRST;
                  data_r  <= load_data_s;
                  id_r    <= load_id_s;
               end else if (ready_i) begin
                  state_r <= EMPTY;
               end else begin
                  state_r <= SEND_SECOND;
               end
            end
            default: begin
               state_r <= EMPTY;
            end
         endcase
      end
   end

   // Handshake outputs; disabled mode is a straight combinational bypass.
   always_comb begin
      data_o  = data_r;
      id_o    = id_r;
      valid_o = 1'b0;
      ready_o = 1'b0;
      if (enable_i) begin
         case (state_r)
            EMPTY: begin
               valid_o = 1'b0;
               ready_o = ~retry_block_s;
            end
            SEND_FIRST: begin
               valid_o = 1'b1;
               ready_o = 1'b0;
            end
            SEND_SECOND: begin
               valid_o = 1'b1;
               ready_o = ready_i & ~retry_block_s;
            end
            default: begin
               valid_o = 1'b0;
               ready_o = 1'b0;
            end
         endcase
      end else begin
         data_o  = data_i;
         id_o    = next_id_s;
         valid_o = valid_i;
         ready_o = ready_i;
      end
   end

endmodule

// File: tb/tb_time_dmr_start.sv
// Directed bench for time_dmr_start: vector table plus wrap and retry sequences.
module tb_time_dmr_start;

   logic       clk;
   logic       rst_ni;
   logic       enable_i;
   logic [7:0] data_i;
   logic       valid_i;
   logic       ready_i;

   logic [1:0] d2_next_id;
   logic       d2_ready;
   logic [7:0] d2_data;
   logic [1:0] d2_id;
   logic       d2_valid;

   logic [2:0] d3_next_id;
   logic       d3_ready;
   logic [7:0] d3_data;
   logic [2:0] d3_id;
   logic       d3_valid;

`ifdef TIME_DMR_RETRY_EN
   logic [7:0] retry_data;
   logic [1:0] retry_id2;
   logic [2:0] retry_id3;
   logic       retry_valid;
   logic       d2_retry_ready;
   logic       d3_retry_ready;
`endif

   int checks   = 0;
   int failures = 0;

   time_dmr_start #(.DataType(logic [7:0]), .IDSize(2)) dut2 (
      .clk_i        (clk),
      .rst_ni       (rst_ni),
      .enable_i     (enable_i),
      .next_id_o    (d2_next_id),
      .data_i       (data_i),
      .valid_i      (valid_i),
      .ready_o      (d2_ready),
`ifdef TIME_DMR_RETRY_EN
      .retry_data_i (retry_data),
      .retry_id_i   (retry_id2),
      .retry_valid_i(retry_valid),
      .retry_ready_o(d2_retry_ready),
`endif
      .data_o       (d2_data),
      .id_o         (d2_id),
      .valid_o      (d2_valid),
      .ready_i      (ready_i)
   );

   time_dmr_start #(.DataType(logic [7:0]), .IDSize(3)) dut3 (
      .clk_i        (clk),
      .rst_ni       (rst_ni),
      .enable_i     (enable_i),
      .next_id_o    (d3_next_id),
      .data_i       (data_i),
      .valid_i      (valid_i),
      .ready_o      (d3_ready),
`ifdef TIME_DMR_RETRY_EN
      .retry_data_i (retry_data),
      .retry_id_i   (retry_id3),
      .retry_valid_i(retry_valid),
      .retry_ready_o(d3_retry_ready),
`endif
      .data_o       (d3_data),
      .id_o         (d3_id),
      .valid_o      (d3_valid),
      .ready_i      (ready_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       rst;
      logic       en;
      logic       vld;
      logic [7:0] din;
      logic       rdy;
      logic       e_vld;
      logic       e_rdy;
      logic [7:0] e_dat;
      logic [1:0] e_id;
      logic [1:0] e_nid;
   } vec_t;

   vec_t vecs[32];

   function automatic vec_t mk(input logic rst, input logic en, input logic vld,
                               input logic [7:0] din, input logic rdy,
                               input logic e_vld, input logic e_rdy, input logic [7:0] e_dat,
                               input logic [1:0] e_id, input logic [1:0] e_nid);
      vec_t v;
      v.rst = rst; v.en = en; v.vld = vld; v.din = din; v.rdy = rdy;
      v.e_vld = e_vld; v.e_rdy = e_rdy; v.e_dat = e_dat; v.e_id = e_id; v.e_nid = e_nid;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_ni   = 1'b0;
      enable_i = 1'b1;
      valid_i  = 1'b0;
      ready_i  = 1'b1;
      data_i   = 8'h00;
`ifdef TIME_DMR_RETRY_EN
      retry_valid = 1'b0;
`endif
      @(negedge clk);
      @(negedge clk);
      rst_ni = 1'b1;
   endtask

   logic [2:0] wrap_exp[10];
   int         hs;
   int         n;

   initial begin
      rst_ni   = 1'b0;
      enable_i = 1'b1;
      valid_i  = 1'b0;
      ready_i  = 1'b1;
      data_i   = 8'h00;
`ifdef TIME_DMR_RETRY_EN
      retry_valid = 1'b0;
      retry_data  = 8'h99;
      retry_id2   = 2'b11;
      retry_id3   = 3'b011;
`endif

      // rst en v din r | valid ready data id next_id
      vecs[0]  = mk(1'b0,1'b1,1'b1,8'h11,1'b1, 1'b0,1'b1,8'h00,2'd0,2'd0);
      vecs[1]  = mk(1'b0,1'b1,1'b1,8'h22,1'b1, 1'b1,1'b0,8'h11,2'd0,2'd3);
      vecs[2]  = mk(1'b0,1'b1,1'b1,8'h22,1'b1, 1'b1,1'b1,8'h11,2'd0,2'd3);
      vecs[3]  = mk(1'b0,1'b1,1'b1,8'h33,1'b1, 1'b1,1'b0,8'h22,2'd3,2'd0);
      vecs[4]  = mk(1'b0,1'b1,1'b1,8'h33,1'b1, 1'b1,1'b1,8'h22,2'd3,2'd0);
      vecs[5]  = mk(1'b0,1'b1,1'b1,8'h44,1'b1, 1'b1,1'b0,8'h33,2'd0,2'd3);
      vecs[6]  = mk(1'b0,1'b1,1'b1,8'h44,1'b1, 1'b1,1'b1,8'h33,2'd0,2'd3);
      vecs[7]  = mk(1'b0,1'b1,1'b0,8'h00,1'b1, 1'b1,1'b0,8'h44,2'd3,2'd0);
      vecs[8]  = mk(1'b0,1'b1,1'b0,8'h00,1'b1, 1'b1,1'b1,8'h44,2'd3,2'd0);
      vecs[9]  = mk(1'b0,1'b1,1'b0,8'h00,1'b1, 1'b0,1'b1,8'h44,2'd3,2'd0);
      vecs[10] = mk(1'b0,1'b1,1'b1,8'hA5,1'b1, 1'b0,1'b1,8'h44,2'd3,2'd0);
      vecs[11] = mk(1'b0,1'b1,1'b0,8'h00,1'b1, 1'b1,1'b0,8'hA5,2'd0,2'd3);
      vecs[12] = mk(1'b0,1'b1,1'b0,8'h00,1'b1, 1'b1,1'b1,8'hA5,2'd0,2'd3);
      vecs[13] = mk(1'b0,1'b1,1'b0,8'h00,1'b1, 1'b0,1'b1,8'hA5,2'd0,2'd3);
      vecs[14] = mk(1'b0,1'b1,1'b1,8'h5A,1'b1, 1'b0,1'b1,8'hA5,2'd0,2'd3);
      vecs[15] = mk(1'b0,1'b1,1'b0,8'h00,1'b0, 1'b1,1'b0,8'h5A,2'd3,2'd0);
      vecs[16] = mk(1'b0,1'b1,1'b0,8'h00,1'b0, 1'b1,1'b0,8'h5A,2'd3,2'd0);
      vecs[17] = mk(1'b0,1'b1,1'b0,8'h00,1'b0, 1'b1,1'b0,8'h5A,2'd3,2'd0);
      vecs[18] = mk(1'b0,1'b1,1'b1,8'h77,1'b1, 1'b1,1'b0,8'h5A,2'd3,2'd0);
      vecs[19] = mk(1'b0,1'b1,1'b0,8'h00,1'b0, 1'b1,1'b0,8'h5A,2'd3,2'd0);
      vecs[20] = mk(1'b0,1'b1,1'b0,8'h00,1'b1, 1'b1,1'b1,8'h5A,2'd3,2'd0);
      vecs[21] = mk(1'b0,1'b1,1'b0,8'h00,1'b1, 1'b0,1'b1,8'h5A,2'd3,2'd0);
      vecs[22] = mk(1'b0,1'b0,1'b1,8'h3C,1'b0, 1'b1,1'b0,8'h3C,2'd0,2'd0);
      vecs[23] = mk(1'b0,1'b0,1'b0,8'h3C,1'b1, 1'b0,1'b1,8'h3C,2'd0,2'd0);
      vecs[24] = mk(1'b0,1'b1,1'b1,8'hC3,1'b1, 1'b0,1'b1,8'h5A,2'd3,2'd0);
      vecs[25] = mk(1'b0,1'b1,1'b0,8'h00,1'b1, 1'b1,1'b0,8'hC3,2'd0,2'd3);
      vecs[26] = mk(1'b0,1'b0,1'b0,8'h00,1'b0, 1'b0,1'b0,8'h00,2'd3,2'd3);
      vecs[27] = mk(1'b0,1'b1,1'b0,8'h00,1'b1, 1'b0,1'b1,8'hC3,2'd0,2'd3);
      vecs[28] = mk(1'b0,1'b1,1'b1,8'hE1,1'b0, 1'b0,1'b1,8'hC3,2'd0,2'd3);
      vecs[29] = mk(1'b0,1'b1,1'b0,8'h00,1'b0, 1'b1,1'b0,8'hE1,2'd3,2'd0);
      vecs[30] = mk(1'b1,1'b1,1'b0,8'h00,1'b1, 1'b0,1'b1,8'h00,2'd0,2'd0);
      vecs[31] = mk(1'b0,1'b1,1'b0,8'h00,1'b1, 1'b0,1'b1,8'h00,2'd0,2'd0);

      do_reset();

      hs = 0;
      for (int i = 0; i < 32; i++) begin
         @(negedge clk);
         rst_ni   = ~vecs[i].rst;
         enable_i = vecs[i].en;
         valid_i  = vecs[i].vld;
         data_i   = vecs[i].din;
         ready_i  = vecs[i].rdy;
         #1;
         check($sformatf("row%0d valid_o", i),   32'(d2_valid),   32'(vecs[i].e_vld));
         check($sformatf("row%0d ready_o", i),   32'(d2_ready),   32'(vecs[i].e_rdy));
         check($sformatf("row%0d data_o", i),    32'(d2_data),    32'(vecs[i].e_dat));
         check($sformatf("row%0d id_o", i),      32'(d2_id),      32'(vecs[i].e_id));
         check($sformatf("row%0d next_id_o", i), 32'(d2_next_id), 32'(vecs[i].e_nid));
         if (i >= 14 && i <= 21 && d2_valid && ready_i) hs++;
      end
      check("backpressure handshakes", 32'(hs), 32'd2);

      // Wrap with a 3-bit ID: counter order 0,1,2,3,0 gives IDs 000,101,110,011,000.
      wrap_exp[0] = 3'b000; wrap_exp[1] = 3'b000;
      wrap_exp[2] = 3'b101; wrap_exp[3] = 3'b101;
      wrap_exp[4] = 3'b110; wrap_exp[5] = 3'b110;
      wrap_exp[6] = 3'b011; wrap_exp[7] = 3'b011;
      wrap_exp[8] = 3'b000; wrap_exp[9] = 3'b000;
      do_reset();
      n = 0;
      for (int c = 0; c < 24 && n < 10; c++) begin
         @(negedge clk);
         enable_i = 1'b1;
         valid_i  = 1'b1;
         ready_i  = 1'b1;
         data_i   = 8'(c + 16);
         #1;
         if (d3_valid && ready_i) begin
            check($sformatf("wrap id %0d", n), 32'(d3_id), 32'(wrap_exp[n]));
            check($sformatf("wrap parity %0d", n), 32'(^d3_id), 32'd0);
            n++;
         end
      end
      check("wrap handshake count", 32'(n), 32'd10);
      valid_i = 1'b0;

`ifdef TIME_DMR_RETRY_EN
      do_reset();
      @(negedge clk);
      valid_i     = 1'b1;
      data_i      = 8'h66;
      ready_i     = 1'b1;
      retry_valid = 1'b1;
      #1;
      check("retry ready_o blocked", 32'(d2_ready), 32'd0);
      check("retry_ready_o", 32'(d2_retry_ready), 32'd1);
      check("retry valid_o idle", 32'(d2_valid), 32'd0);
      @(negedge clk);
      retry_valid = 1'b0;
      #1;
      check("retry first valid", 32'(d2_valid), 32'd1);
      check("retry first data", 32'(d2_data), 32'h99);
      check("retry first id", 32'(d2_id), 32'd3);
      check("retry cnt held", 32'(d2_next_id), 32'd0);
      @(negedge clk);
      #1;
      check("retry second data", 32'(d2_data), 32'h99);
      check("retry second id", 32'(d2_id), 32'd3);
      check("retry second ready_o", 32'(d2_ready), 32'd1);
      @(negedge clk);
      valid_i = 1'b0;
      #1;
      check("after retry data", 32'(d2_data), 32'h66);
      check("after retry id", 32'(d2_id), 32'd0);
      check("after retry next_id", 32'(d2_next_id), 32'd3);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
